// File: rtl/kd_root_ctrl.sv
// -----------------------------------------------------------------------------
// kd_root_ctrl
//
// Top-level controller for a k-d tree build. A single start request runs the
// whole sequence against the root node: reset the tree, stream the centers in,
// configure the sort axis, kick the sort and wait for the tree to report a
// stable ready_to_sort. The captured root center is then presented on
// o_root_center until the next accepted start.
//
// Ports
//   i_clk, i_rst            : clock, synchronous active-high reset
//   i_start                 : one-cycle build request (honoured in IDLE/ERROR)
//   i_num_centers           : number of centers for this run (sampled on start)
//   i_sort_axis             : sort axis for this run (sampled on start)
//   i_center_valid/_data    : upstream center stream
//   o_center_ready          : upstream ready (combinational)
//   o_command_to_node       : command to root node (registered)
//   o_data_to_node          : data to root node (registered)
//   i_command_from_node     : response command from root node
//   i_data_from_node        : response data from root node
//   o_busy, o_done, o_error : status (registered)
//   o_root_center           : final root center (registered)
//   o_state                 : current FSM state, for observation
//
// Handshake: a center beat transfers on a rising edge where both
// i_center_valid and o_center_ready are high. The source may raise valid at
// any time and must hold data stable while valid is high and ready is low;
// ready never depends on valid.
// -----------------------------------------------------------------------------
module kd_root_ctrl #(
  parameter int TIMEOUT       = 1024,
  parameter int STABLE_CYCLES = 4,
  parameter int MAX_CENTERS   = 16
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               i_start,
  input  logic [$clog2(MAX_CENTERS+1)-1:0]   i_num_centers,
  input  logic [1:0]                         i_sort_axis,
  input  logic                               i_center_valid,
  input  logic [23:0]                        i_center_data,
  output logic                               o_center_ready,
  output logic [4:0]                         o_command_to_node,
  output logic [23:0]                        o_data_to_node,
  input  logic [4:0]                         i_command_from_node,
  input  logic [23:0]                        i_data_from_node,
  output logic                               o_busy,
  output logic                               o_done,
  output logic                               o_error,
  output logic [23:0]                        o_root_center,
  output logic [2:0]                         o_state
);

  localparam int CW = $clog2(MAX_CENTERS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(STABLE_CYCLES + 1);

  localparam logic [CW-1:0] MAX_CNT     = CW'(MAX_CENTERS);
  localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT - 1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);

  // Root node command codes
  localparam logic [4:0] CMD_NOP           = 5'h00;
  localparam logic [4:0] CMD_CENTER_FILL   = 5'h01;
  localparam logic [4:0] CMD_CFG_AXIS      = 5'h02;
  localparam logic [4:0] CMD_FILL_DONE     = 5'h05;
  localparam logic [4:0] CMD_CFG_AXIS_DONE = 5'h07;
  localparam logic [4:0] CMD_START_SORT    = 5'h09;
  localparam logic [4:0] CMD_READY_TO_SORT = 5'h0a;
  localparam logic [4:0] CMD_RST_DONE      = 5'h1e;
  localparam logic [4:0] CMD_RST           = 5'h1f;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_TREE_RST  = 3'd1,
    S_FILL      = 3'd2,
    S_AXIS      = 3'd3,
    S_SORT_KICK = 3'd4,
    S_SORT_WAIT = 3'd5,
    S_DONE      = 3'd6,
    S_ERROR     = 3'd7
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_num;
  logic [1:0]      r_axis;
  logic [CW-1:0]   r_count;
  logic [TW-1:0]   r_tmo;
  logic [SW-1:0]   r_stable;
  logic [4:0]      r_cmd;
  logic [23:0]     r_data;
  logic            r_busy;
  logic            r_done;
  logic            r_error;
  logic [23:0]     r_root;

  logic            w_center_ready;
  logic            w_accept;
  logic            w_start_ok;
  logic            w_num_bad;
  logic            w_tmo_hit;
  logic            w_stable_hit;

  // Ready drops in the cycle the node reports fill done, so a beat offered
  // alongside that report is never taken.
  assign w_center_ready = (r_state == S_FILL) &&
                          (i_command_from_node != CMD_FILL_DONE) &&
                          (r_count < r_num);
  assign w_accept       = w_center_ready && i_center_valid;

  // A start is only honoured when no build is in flight.
  assign w_start_ok     = i_start && ((r_state == S_IDLE) || (r_state == S_ERROR));
  assign w_num_bad      = (i_num_centers == '0) || (i_num_centers > MAX_CNT);

  // Asserted on the edge that would complete TIMEOUT cycles in a waiting state.
  assign w_tmo_hit      = (r_tmo == TMO_LAST);
  assign w_stable_hit   = (i_command_from_node == CMD_READY_TO_SORT) &&
                          (r_stable == STABLE_LAST);

  // Registered outputs are loaded together with the state they belong to, so
  // the node sees the new command in the first cycle of the new state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_num    <= '0;
      r_axis   <= '0;
      r_count  <= '0;
      r_tmo    <= '0;
      r_stable <= '0;
      r_cmd    <= CMD_NOP;
      r_data   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
      r_root   <= '0;
    end else begin
      r_done <= 1'b0;
      r_cmd  <= CMD_NOP;
      r_data <= '0;

      if (w_start_ok) begin
        r_num    <= i_num_centers;
        r_axis   <= i_sort_axis;
        r_count  <= '0;
        r_tmo    <= '0;
        r_stable <= '0;
        r_root   <= '0;
        if (w_num_bad) begin
          // Illegal size: fail without touching the tree.
          r_state <= S_ERROR;
          r_busy  <= 1'b0;
          r_error <= 1'b1;
        end else begin
          r_state <= S_TREE_RST;
          r_busy  <= 1'b1;
          r_error <= 1'b0;
          r_cmd   <= CMD_RST;
        end
      end else begin
        case (r_state)
          S_TREE_RST: begin
            if (i_command_from_node == CMD_RST_DONE) begin
              r_state <= S_FILL;
              r_tmo   <= '0;
            end else if (w_tmo_hit) begin
              r_state <= S_ERROR;
              r_busy  <= 1'b0;
              r_error <= 1'b1;
              r_tmo   <= '0;
            end else begin
              r_tmo <= r_tmo + 1'b1;
              r_cmd <= CMD_RST;
            end
          end

          S_FILL: begin
            if (i_command_from_node == CMD_FILL_DONE) begin
              r_tmo <= '0;
              if (r_count == r_num) begin
                r_state <= S_AXIS;
                r_cmd   <= CMD_CFG_AXIS;
                r_data  <= {22'b0, r_axis};
              end else begin
                r_state <= S_ERROR;
                r_busy  <= 1'b0;
                r_error <= 1'b1;
              end
            end else if (w_tmo_hit) begin
              r_state <= S_ERROR;
              r_busy  <= 1'b0;
              r_error <= 1'b1;
              r_tmo   <= '0;
            end else begin
              // Stalls keep the timeout running; only accepted beats are
              // forwarded, everything else goes out as nop.
              r_tmo <= r_tmo + 1'b1;
              if (w_accept) begin
                r_cmd  <= CMD_CENTER_FILL;
                r_data <= i_center_data;
                if (r_count != MAX_CNT) begin
                  r_count <= r_count + 1'b1;
                end
              end
            end
          end

          S_AXIS: begin
            if (i_command_from_node == CMD_CFG_AXIS_DONE) begin
              r_state <= S_SORT_KICK;
              r_tmo   <= '0;
              r_cmd   <= CMD_START_SORT;
              r_data  <= {22'b0, r_axis};
            end else if (w_tmo_hit) begin
              r_state <= S_ERROR;
              r_busy  <= 1'b0;
              r_error <= 1'b1;
              r_tmo   <= '0;
            end else begin
              r_tmo  <= r_tmo + 1'b1;
              r_cmd  <= CMD_CFG_AXIS;
              r_data <= {22'b0, r_axis};
            end
          end

          S_SORT_KICK: begin
            // start_sorting is visible for exactly this one cycle.
            r_state  <= S_SORT_WAIT;
            r_tmo    <= '0;
            r_stable <= '0;
          end

          S_SORT_WAIT: begin
            if (w_stable_hit) begin
              r_state  <= S_DONE;
              r_root   <= i_data_from_node;
              r_done   <= 1'b1;
              r_busy   <= 1'b0;
              r_tmo    <= '0;
              r_stable <= '0;
            end else if (w_tmo_hit) begin
              r_state  <= S_ERROR;
              r_busy   <= 1'b0;
              r_error  <= 1'b1;
              r_tmo    <= '0;
              r_stable <= '0;
            end else begin
              r_tmo <= r_tmo + 1'b1;
              // Any other response breaks the run of ready_to_sort.
              if (i_command_from_node == CMD_READY_TO_SORT) begin
                r_stable <= r_stable + 1'b1;
              end else begin
                r_stable <= '0;
              end
            end
          end

          S_DONE: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end

          S_IDLE: begin
            r_busy <= 1'b0;
          end

          S_ERROR: begin
            // Sticky until reset or a new start.
            r_busy  <= 1'b0;
            r_error <= 1'b1;
          end

          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_center_ready    = w_center_ready;
  assign o_command_to_node = r_cmd;
  assign o_data_to_node    = r_data;
  assign o_busy            = r_busy;
  assign o_done            = r_done;
  assign o_error           = r_error;
  assign o_root_center     = r_root;
  assign o_state           = r_state;

endmodule
